branch_hazard_ctrl: RTL and testbench

//   Decode-stage branch sequencer for the 5-stage MIPS pipeline. Detects operand

---
 rtl/branch_hazard_ctrl_if.sv | 49 ++++
 rtl/branch_hazard_ctrl.sv | 143 ++++++++++++++
 tb/tb_branch_hazard_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/branch_hazard_ctrl_if.sv
// Bundle of decode-stage branch signals exchanged between the pipeline datapath
// (master) and the branch hazard sequencer (slave). The statistics counters are
// always present; they read as zero when BRANCH_STATS_EN is not defined in the
// sequencer build.
interface branch_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int STAT_W = 32
);
    // Decode-stage instruction
    logic [5:0]        OpD;
    logic [REG_AW-1:0] RsD;
    logic [REG_AW-1:0] RtD;
    logic              ConditionD;
    // Writers further down the pipe
    logic              RegWriteE;
    logic              MemtoRegE;
    logic [REG_AW-1:0] WriteRegE;
    logic              RegWriteM;
    logic              MemtoRegM;
    logic [REG_AW-1:0] WriteRegM;
    // Control back to the datapath
    logic              StallF;
    logic              StallD;
    logic              FlushE;
    logic              FlushD;
    logic              PCSrcD;
    logic              ForwardAD;
    logic              ForwardBD;
    // Statistics
    logic [STAT_W-1:0] BrCount;
    logic [STAT_W-1:0] TakenCount;
    logic [STAT_W-1:0] StallCycles;

    modport master (
        output OpD, RsD, RtD, ConditionD,
        output RegWriteE, MemtoRegE, WriteRegE,
        output RegWriteM, MemtoRegM, WriteRegM,
        input  StallF, StallD, FlushE, FlushD, PCSrcD, ForwardAD, ForwardBD,
        input  BrCount, TakenCount, StallCycles
    );

    modport slave (
        input  OpD, RsD, RtD, ConditionD,
        input  RegWriteE, MemtoRegE, WriteRegE,
        input  RegWriteM, MemtoRegM, WriteRegM,
        output StallF, StallD, FlushE, FlushD, PCSrcD, ForwardAD, ForwardBD,
        output BrCount, TakenCount, StallCycles
    );
endinterface

// File: rtl/branch_hazard_ctrl.sv
// Decode-stage branch sequencer for the 5-stage MIPS pipeline.
// Detects operand hazards for bne/bbt in D, stalls F/D and bubbles E until the
// operands are readable, selects M->D forwarding and resolves the branch from
// the combinational ConditionD (PCSrcD / FlushD on a taken branch).
// Optional feature: define BRANCH_STATS_EN to build saturating branch/taken/stall
// counters; otherwise the counter outputs are tied to zero and no flops exist.
module branch_hazard_ctrl #(
    parameter int         REG_AW = 5,
    parameter logic [5:0] OP_BNE = 6'b000100,
    parameter logic [5:0] OP_BBT = 6'b111111,
    parameter int         STAT_W = 32
) (
    input logic                clk,
    input logic                rst_n,
    branch_hazard_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STALL   = 2'd1,
        RESOLVE = 2'd2
    } state_t;

    state_t     state;
    logic [1:0] cnt;

    logic       isBne;
    logic       branchD;
    logic       useHitE;
    logic       useHitM;
    logic [1:0] need;
    logic       stallNow;
    logic       resolveNow;

    // Register $0 is hard-wired, so it never carries a dependency.
    function automatic logic hit(input logic [REG_AW-1:0] r, input logic [REG_AW-1:0] w);
        return (r != '0) && (r == w);
    endfunction

    // Hazard depth: how many cycles the branch must wait for its operands.
    // Rt is only a source for bne; for bbt it is a bit index.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        need    = 2'd0;
        isBne   = (bus.OpD == OP_BNE);
        branchD = isBne || (bus.OpD == OP_BBT);
        useHitE = hit(bus.RsD, bus.WriteRegE) || (isBne && hit(bus.RtD, bus.WriteRegE));
        useHitM = hit(bus.RsD, bus.WriteRegM) || (isBne && hit(bus.RtD, bus.WriteRegM));
        // Priority order yields the maximum of simultaneous E and M hazards.
        if (bus.RegWriteE && bus.MemtoRegE && useHitE) begin
            need = 2'd2;
        end else if ((bus.RegWriteE && useHitE) ||
                     (bus.RegWriteM && bus.MemtoRegM && useHitM)) begin
            need = 2'd1;
        end
    end

    // Stall and resolve qualifiers; the detection cycle in IDLE is the first stall cycle.
    always_comb begin
        stallNow   = (state == STALL) || ((state == IDLE) && branchD && (need != 2'd0));
        resolveNow = (state == RESOLVE) || ((state == IDLE) && branchD && (need == 2'd0));
    end

    // Outputs are forced low while reset is held so a branch sitting in D
    // cannot stall the pipe until reset is released.
    assign bus.StallF    = rst_n && stallNow;
    assign bus.StallD    = rst_n && stallNow;
    assign bus.FlushE    = rst_n && stallNow;
    assign bus.PCSrcD    = rst_n && resolveNow && bus.ConditionD;
    assign bus.FlushD    = rst_n && resolveNow && bus.ConditionD;
    assign bus.ForwardAD = rst_n && branchD && hit(bus.RsD, bus.WriteRegM) &&
                           bus.RegWriteM && !bus.MemtoRegM;
    assign bus.ForwardBD = rst_n && isBne && hit(bus.RtD, bus.WriteRegM) &&
                           bus.RegWriteM && !bus.MemtoRegM;

    // Sequencer: IDLE detects, STALL counts remaining stall cycles, RESOLVE fires once.
    // cnt holds the STALL-state cycles still owed after the current one, so a
    // one-cycle hazard goes straight to RESOLVE and the total stall equals need.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 2'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            case (state)
                IDLE: begin
                    if (branchD && (need != 2'd0)) begin
                        cnt   <= need - 2'd2;
                        state <= (need == 2'd1) ? RESOLVE : STALL;
                    end
                end
                STALL: begin
                    if (cnt == 2'd0) begin
                        state <= RESOLVE;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                RESOLVE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 2'd0;
                end
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    logic [STAT_W-1:0] brCount;
    logic [STAT_W-1:0] takenCount;
    logic [STAT_W-1:0] stallCycles;

    // Saturating statistics: resolved branches, taken branches, stalled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            brCount     <= '0;
            takenCount  <= '0;
            stallCycles <= '0;
        end else begin
            if (resolveNow && (brCount != '1)) begin
                brCount <= brCount + STAT_W'(1);
            end
            if (resolveNow && bus.ConditionD && (takenCount != '1)) begin
                takenCount <= takenCount + STAT_W'(1);
            end
            if (stallNow && (stallCycles != '1)) begin
                stallCycles <= stallCycles + STAT_W'(1);
            end
        end
    end

    assign bus.BrCount     = brCount;
    assign bus.TakenCount  = takenCount;
    assign bus.StallCycles = stallCycles;
`else
    assign bus.BrCount     = '0;
    assign bus.TakenCount  = '0;
    assign bus.StallCycles = '0;
`endif

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed bench for branch_hazard_ctrl: inputs change 1 time unit after the
// rising edge, outputs are compared on the falling edge.
module tb_branch_hazard_ctrl;

    localparam logic [5:0] BNE = 6'b000100;
    localparam logic [5:0] BBT = 6'b111111;
    localparam logic [5:0] ADD = 6'b000000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   passed = 0;
    int   total = 0;

    always #5 clk = ~clk;

    branch_hazard_ctrl_if #(.REG_AW(5), .STAT_W(32)) bus ();

    branch_hazard_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // {StallF, StallD, FlushE, FlushD, PCSrcD, ForwardAD, ForwardBD}
    logic [6:0] ctl;
    assign ctl = {bus.StallF, bus.StallD, bus.FlushE, bus.FlushD,
                  bus.PCSrcD, bus.ForwardAD, bus.ForwardBD};

    task automatic setD(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic cond);
        bus.OpD = op; bus.RsD = rs; bus.RtD = rt; bus.ConditionD = cond;
    endtask

    task automatic setE(input logic rw, input logic mtr, input logic [4:0] wr);
        bus.RegWriteE = rw; bus.MemtoRegE = mtr; bus.WriteRegE = wr;
    endtask

    task automatic setM(input logic rw, input logic mtr, input logic [4:0] wr);
        bus.RegWriteM = rw; bus.MemtoRegM = mtr; bus.WriteRegM = wr;
    endtask

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic checkCtl(input string tag, input logic [6:0] exp);
        @(negedge clk);
        checkVal(tag, {25'd0, ctl}, {25'd0, exp});
    endtask

    // Counters read zero unless the statistics feature is built in.
    task automatic checkStats(input string tag, input int b, input int t, input int s);
`ifdef BRANCH_STATS_EN
        checkVal({tag, ".BrCount"},     bus.BrCount,     b);
        checkVal({tag, ".TakenCount"},  bus.TakenCount,  t);
        checkVal({tag, ".StallCycles"}, bus.StallCycles, s);
`else
        checkVal({tag, ".BrCount"},     bus.BrCount,     0);
        checkVal({tag, ".TakenCount"},  bus.TakenCount,  0);
        checkVal({tag, ".StallCycles"}, bus.StallCycles, 0);
        if (b + t + s < 0) $display("unreachable");
`endif
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        setD(ADD, 5'd0, 5'd0, 1'b0);
        setE(1'b0, 1'b0, 5'd0);
        setM(1'b0, 1'b0, 5'd0);

        // Reset state, with a hazardous branch already in D
        setD(BNE, 5'd8, 5'd9, 1'b1);
        setE(1'b1, 1'b1, 5'd8);
        checkCtl("reset_outputs", 7'b0000000);
        checkStats("reset", 0, 0, 0);
        nextCycle();
        setD(ADD, 5'd0, 5'd0, 1'b0);
        setE(1'b0, 1'b0, 5'd0);
        rst_n = 1'b1;

        // 1: bne $8,$9 taken, no writers -> resolve immediately
        setD(BNE, 5'd8, 5'd9, 1'b1);
        checkCtl("t1_resolve", 7'b0001100);
        nextCycle();

        // Non-branch with a matching E writer -> all outputs low
        setD(ADD, 5'd8, 5'd9, 1'b1);
        setE(1'b1, 1'b1, 5'd8);
        checkCtl("nonbranch", 7'b0000000);
        checkStats("after_t1", 1, 1, 0);
        nextCycle();

        // 2: lw $8 in E, bne $8,$9 -> two stall cycles then resolve
        setD(BNE, 5'd8, 5'd9, 1'b1);
        setE(1'b1, 1'b1, 5'd8);
        checkCtl("t2_stall0", 7'b1110000);
        nextCycle();
        setE(1'b0, 1'b0, 5'd0);
        setM(1'b1, 1'b1, 5'd8);
        checkCtl("t2_stall1", 7'b1110000);
        nextCycle();
        setM(1'b0, 1'b0, 5'd0);
        checkCtl("t2_resolve", 7'b0001100);
        nextCycle();
        setD(ADD, 5'd0, 5'd0, 1'b0);
        checkCtl("t2_idle", 7'b0000000);
        checkStats("after_t2", 2, 2, 2);
        nextCycle();

        // 3: add $8 in E, bbt $8,bit3 -> one stall, then forward A only
        setD(BBT, 5'd8, 5'd3, 1'b0);
        setE(1'b1, 1'b0, 5'd8);
        checkCtl("t3_stall0", 7'b1110000);
        nextCycle();
        setE(1'b0, 1'b0, 5'd0);
        setM(1'b1, 1'b0, 5'd8);
        checkCtl("t3_resolve_fwd", 7'b0000010);
        nextCycle();

        // 4: bbt $4,RtD=8 with add $8 in E and M -> no stall, no forward B
        setD(BBT, 5'd4, 5'd8, 1'b1);
        setE(1'b1, 1'b0, 5'd8);
        setM(1'b1, 1'b0, 5'd8);
        checkCtl("t4_bitindex", 7'b0001100);
        nextCycle();

        // bne Rt fed from an ALU result in M -> forward B, no stall
        setD(BNE, 5'd5, 5'd8, 1'b0);
        setE(1'b0, 1'b0, 5'd0);
        checkCtl("bne_fwdB", 7'b0000001);
        nextCycle();

        // Load in M feeding bne Rt -> one stall
        setD(BNE, 5'd8, 5'd9, 1'b1);
        setM(1'b1, 1'b1, 5'd9);
        checkCtl("mload_stall", 7'b1110000);
        nextCycle();
        setM(1'b0, 1'b0, 5'd0);
        checkCtl("mload_resolve", 7'b0001100);
        nextCycle();

        // Load in E feeding bne Rt -> two stalls, not-taken resolve
        setD(BNE, 5'd3, 5'd8, 1'b0);
        setE(1'b1, 1'b1, 5'd8);
        checkCtl("eload_rt_stall0", 7'b1110000);
        nextCycle();
        setE(1'b0, 1'b0, 5'd0);
        checkCtl("eload_rt_stall1", 7'b1110000);
        nextCycle();
        checkCtl("eload_rt_resolve", 7'b0000000);
        nextCycle();

        // 5: writers to $0, bne $0,$0 -> no stall, taken
        setD(BNE, 5'd0, 5'd0, 1'b1);
        setE(1'b1, 1'b1, 5'd0);
        setM(1'b1, 1'b0, 5'd0);
        checkCtl("t5_reg0", 7'b0001100);
        nextCycle();
        setD(ADD, 5'd0, 5'd0, 1'b0);
        setE(1'b0, 1'b0, 5'd0);
        setM(1'b0, 1'b0, 5'd0);
        checkCtl("t5_idle", 7'b0000000);
        checkStats("after_t5", 8, 5, 6);
        nextCycle();

        // 6: reset in the first STALL cycle, then full restart
        setD(BNE, 5'd8, 5'd9, 1'b1);
        setE(1'b1, 1'b1, 5'd8);
        checkCtl("t6_stall0", 7'b1110000);
        nextCycle();
        rst_n = 1'b0;
        #1;
        checkVal("t6_reset_now", {25'd0, ctl}, 32'd0);
        checkStats("t6_reset", 0, 0, 0);
        nextCycle();
        rst_n = 1'b1;
        checkCtl("t6_restart0", 7'b1110000);
        nextCycle();
        checkCtl("t6_restart1", 7'b1110000);
        nextCycle();
        checkCtl("t6_resolve", 7'b0001100);
        nextCycle();
        setD(ADD, 5'd0, 5'd0, 1'b0);
        setE(1'b0, 1'b0, 5'd0);
        checkCtl("t6_idle", 7'b0000000);
        checkStats("after_t6", 1, 1, 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
